// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory path: access sizes, lane-enable constants,
// the load FSM states and the latched read-request record.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [3:0] WEN_NONE = 4'b0000;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        RD_DONE = 2'b10
    } state_t;

    typedef struct packed {
        logic [1:0] size;
        logic       isUnsigned;
        logic [1:0] offset;
    } rd_req_t;

    // The reserved size encoding behaves as a word, so it needs word alignment too.
    function automatic logic isAligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: isAligned = 1'b1;
            SZ_HALF: isAligned = ~offset[0];
            default: isAligned = (offset == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Bundle between the M stage, the data-memory controller and the data_ram block.
// The controller is the slave; the core/RAM side (or a bench) is the master.
interface dmem_ctrl_if #(
    parameter int RAM_AW = 10
);

    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;

    logic              stall;
    logic [31:0]       rdata_out;
    logic              rdata_valid;
    logic              addr_err_load;
    logic              addr_err_store;

    logic              ram_en;
    logic [3:0]        ram_wen;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
        input  stall, rdata_out, rdata_valid, addr_err_load, addr_err_store,
        input  ram_en, ram_wen, ram_addr, ram_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
        output stall, rdata_out, rdata_valid, addr_err_load, addr_err_store,
        output ram_en, ram_wen, ram_addr, ram_wdata
    );

endinterface

// File: rtl/load_extract.sv
// Picks the addressed byte/half lane out of a little-endian RAM word and
// sign- or zero-extends it to 32 bits.
module load_extract
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  lane8;
    logic [15:0] lane16;

    always_comb begin
        lane8  = word_i[7:0];
        lane16 = offset_i[1] ? word_i[31:16] : word_i[15:0];
        data_o = word_i;

        case (offset_i)
            2'd0:    lane8 = word_i[7:0];
            2'd1:    lane8 = word_i[15:8];
            2'd2:    lane8 = word_i[23:16];
            default: lane8 = word_i[31:24];
        endcase

        case (size_i)
            SZ_BYTE: data_o = {{24{~unsigned_i & lane8[7]}}, lane8};
            SZ_HALF: data_o = {{16{~unsigned_i & lane16[15]}}, lane16};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: stores go straight to the RAM in the request cycle,
// loads stall the pipeline while the one-cycle RAM read is collected and extended.
module dmem_ctrl
    import mem_pkg::*;
#(
    parameter int RAM_AW = 10
) (
    input  logic         clk,
    input  logic         rst,
    dmem_ctrl_if.slave   bus
);

    state_t      state_q;
    rd_req_t     rdReq_q;
    logic [31:0] rdata_q;

    logic        aligned;
    logic        accept;
    logic        doStore;
    logic        doLoad;
    logic [3:0]  storeWen;
    logic [31:0] storeData;
    logic [31:0] extracted;

    // Requests are only looked at in IDLE; reset also masks them so every
    // RAM-side output reads zero while rst is high.
    always_comb begin
        aligned = isAligned(bus.req_size, bus.req_addr[1:0]);
        accept  = (state_q == IDLE) && !rst && bus.req_valid;
        doStore = accept && aligned && bus.req_we;
        doLoad  = accept && aligned && !bus.req_we;
    end

    always_comb begin
        storeWen  = 4'b1111;
        storeData = bus.req_wdata;
        case (bus.req_size)
            SZ_BYTE: begin
                storeWen  = 4'b0001 << bus.req_addr[1:0];
                storeData = {4{bus.req_wdata[7:0]}};
            end
            SZ_HALF: begin
                storeWen  = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                storeData = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                storeWen  = 4'b1111;
                storeData = bus.req_wdata;
            end
        endcase
    end

    always_comb begin
        bus.ram_en         = doStore || doLoad;
        bus.ram_wen        = doStore ? storeWen : WEN_NONE;
        bus.ram_addr       = (doStore || doLoad) ? bus.req_addr[RAM_AW+1:2] : '0;
        bus.ram_wdata      = doStore ? storeData : 32'h0;
        bus.stall          = doLoad || (state_q == RD_WAIT);
        bus.rdata_valid    = (state_q == RD_DONE);
        bus.rdata_out      = rdata_q;
        bus.addr_err_load  = accept && !aligned && !bus.req_we;
        bus.addr_err_store = accept && !aligned && bus.req_we;
    end

    load_extract u_load_extract (
        .word_i     (bus.ram_rdata),
        .offset_i   (rdReq_q.offset),
        .size_i     (rdReq_q.size),
        .unsigned_i (rdReq_q.isUnsigned),
        .data_o     (extracted)
    );

    // The request fields are captured at issue because the pipeline is frozen
    // but the core-side bus is not guaranteed stable while the read is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rdReq_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (doLoad) begin
                        rdReq_q.size       <= bus.req_size;
                        rdReq_q.isUnsigned <= bus.req_unsigned;
                        rdReq_q.offset     <= bus.req_addr[1:0];
                        state_q            <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    rdata_q <= extracted;
                    state_q <= RD_DONE;
                end
                RD_DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller between the pipelined MIPS core's memory stage and the synchronous `data_ram` block RAM. It converts byte/half/word load-store requests into byte-lane enables and lane-replicated write data. It hides the RAM's one-cycle read latency with a stall handshake and returns sign- or zero-extended load data. Misaligned accesses are flagged and suppressed, so they never reach the RAM.

## Interface
Parameters:
- `RAM_AW`, default 10: word-address width of `data_ram`.

Ports:
- `clk`  in  1: single clock; `data_ram` uses the same edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `req_valid`  in  1: M-stage memory access (memread | memwrite).
- `req_we`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- `req_unsigned`  in  1: zero-extend the load (lbu/lhu).
- `req_addr`  in  32: byte address (aluoutM).
- `req_wdata`  in  32: store data (writedataM), right-justified.
- `stall`  out  1: freeze the pipeline (F through M).
- `rdata_out`  out  32: extended load result.
- `rdata_valid`  out  1: `rdata_out` is valid this cycle.
- `addr_err_load`  out  1: misaligned-load pulse.
- `addr_err_store`  out  1: misaligned-store pulse.
- `ram_en`  out  1: RAM enable.
- `ram_wen`  out  4: RAM byte write enables.
- `ram_addr`  out  RAM_AW: word address, `req_addr[RAM_AW+1:2]`.
- `ram_wdata`  out  32: RAM write data.
- `ram_rdata`  in  32: RAM read data, valid one cycle after the address.

## Operation
- FSM states: IDLE, RD_WAIT, RD_DONE. Reset state is IDLE.
- Alignment check:
  - half requires `addr[0]=0`.
  - word requires `addr[1:0]=0`.
  - byte is always aligned.
- IDLE, aligned store:
  - `ram_en=1`.
  - `ram_wen`: byte → `4'b0001<<addr[1:0]`; half → `addr[1] ? 4'b1100 : 4'b0011`; word → `4'b1111`.
  - `ram_wdata`: byte → `{4{wdata[7:0]}}`; half → `{2{wdata[15:0]}}`; word → `wdata`.
  - No stall; state stays IDLE.
- IDLE, aligned load:
  - Drive `ram_en=1`, `ram_wen=0`, `ram_addr`.
  - Latch `size`, `unsigned` and `addr[1:0]` into the request register.
  - `stall=1`; go to RD_WAIT.
- RD_WAIT:
  - `stall=1`.
  - Select a lane from `ram_rdata` using the latched offset (little-endian: offset 0 = bits 7:0), extend it, register the result into `rdata_q`.
  - Go to RD_DONE.
  - Input request signals are ignored in this state.
- RD_DONE:
  - `stall=0`, `rdata_valid=1`, `rdata_out=rdata_q`.
  - The pipeline advances at this edge.
  - Unconditionally return to IDLE; no new request is accepted in RD_DONE.
- Misaligned request in IDLE:
  - `ram_en=0`, `ram_wen=0`, no stall.
  - Pulse `addr_err_load` or `addr_err_store` for 1 cycle (combinational, qualified by `req_valid`).
  - State stays IDLE.
- `req_valid=0`: `ram_en=0`, `ram_wen=0`.
- `rdata_out` holds its last value outside RD_DONE; consumers use it only when `rdata_valid=1`.

## Timing
- Reset values:
  - state IDLE.
  - `stall`, `rdata_valid`, error flags, `ram_en`, `ram_wen` all 0.
  - `rdata_out`, `ram_addr`, `ram_wdata` all 0.
- Store latency: 0 extra cycles; the write commits at the end of the request cycle.
- Load latency: 2 stall cycles (IDLE-issue, RD_WAIT); data is presented in cycle 3 (RD_DONE).
- Back-to-back loads: every load costs 3 cycles. A load following a store costs 3 cycles; a store following a load costs 1 cycle.
- `stall` is combinational from state and request, and must settle within the same cycle.
- Reset asserted mid-load: the FSM returns to IDLE at once and drops `stall`; the in-flight read is discarded with no `rdata_valid`.

## Structure
- `mem_pkg` holds:
  - Size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - The FSM state enum (IDLE, RD_WAIT, RD_DONE).
  - The `WEN_NONE` constant.
- Sub-module `load_extract`: combinational lane select plus sign/zero extension (inputs: word, offset, size, unsigned). It is reused by any later cache or uncached path.

## Test plan
- sw 0x12345678 to 0x10, then lw 0x10 → `ram_wen=1111` with no stall; lw gives stall high 2 cycles, then `rdata_out=0x12345678` with `rdata_valid=1`.
- sb 0xAB to 0x13 → `ram_wen=1000`, `ram_wdata=0xABABABAB`; then lb 0x13 → `0xFFFFFFAB`, and lbu 0x13 → `0x000000AB`.
- sh 0x8001 to 0x22 → `ram_wen=1100`; then lh 0x22 → `0xFFFF8001`, and lhu 0x22 → `0x00008001`.
- lw 0x06 → `addr_err_load=1` for 1 cycle, `ram_en=0`, no stall. sh to 0x05 → `addr_err_store=1`, `ram_wen=0000`.
- Assert `rst` during RD_WAIT → next cycle state is IDLE, `stall=0`, and no `rdata_valid` pulse ever appears for that load.
- lw 0x10 followed immediately by lw 0x14 (the second held until the first completes) → each takes exactly 3 cycles and returns the correct distinct data.
